fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin burst arbiter sharing one async-FIFO write port
//            between NUM_REQ requesters, throttled by the FIFO full flag.
//            Optional statistics counters: define FIFO_WR_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic                     o_wr_en,
    output logic [WIDTH-1:0]         o_wr_data,
    input  logic                     i_wr_full,
    output logic                     o_busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [31:0]              o_stat_words,
    output logic [31:0]              o_stat_stalls
`endif
);

    localparam int c_PTR_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(MAX_BURST - 1);
    localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(NUM_REQ - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]          r_state, w_state_nxt;
    logic [c_PTR_W-1:0]  r_rr_ptr, w_rr_nxt;
    logic [c_PTR_W-1:0]  r_gnt_idx, w_gnt_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;

    logic                w_sel_found;
    logic [c_PTR_W-1:0]  w_sel_idx;
    logic                w_gnt_valid;
    logic                w_xfer;
    logic [c_PTR_W-1:0]  w_rr_after;
    logic [NUM_REQ-1:0]  w_gnt_onehot;

    // Walk offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin : p_select
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = c_PTR_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_gnt_valid  = i_req_valid[r_gnt_idx];
    assign w_xfer       = (r_state == S_BURST) && w_gnt_valid && !i_wr_full && !rst;
    assign w_rr_after   = (r_gnt_idx == c_LAST_IDX) ? '0 : r_gnt_idx + 1'b1;
    assign w_gnt_onehot = NUM_REQ'(1) << r_gnt_idx;

    assign o_wr_en     = w_xfer;
    assign o_req_ready = w_xfer ? w_gnt_onehot : '0;
    assign o_grant     = (r_state == S_BURST) ? w_gnt_onehot : '0;
    assign o_busy      = (r_state == S_BURST);
    assign o_wr_data   = (r_state == S_BURST) ? i_req_data[int'(r_gnt_idx)*WIDTH +: WIDTH]
                                              : '0;

    always_comb begin : p_next
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_idx;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_sel_found) begin
                    w_state_nxt = S_BURST;
                    w_gnt_nxt   = w_sel_idx;
                    w_cnt_nxt   = '0;
                end
            end
            S_BURST: begin
                // Dropping valid ends the burst without a transfer that cycle.
                if (!w_gnt_valid) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = w_rr_after;
                    w_cnt_nxt   = '0;
                end else if (w_xfer) begin
                    if (r_cnt == c_LAST_CNT) begin
                        w_state_nxt = S_IDLE;
                        w_rr_nxt    = w_rr_after;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin : p_regs
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_gnt_idx <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_gnt_idx <= w_gnt_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic w_stall;
    assign w_stall = (r_state == S_BURST) && w_gnt_valid && i_wr_full;

    always_ff @(posedge clk) begin : p_stats
        if (rst) begin
            o_stat_words  <= '0;
            o_stat_stalls <= '0;
        end else begin
            if (w_xfer && (o_stat_words != '1)) begin
                o_stat_words <= o_stat_words + 32'd1;
            end
            if (w_stall && (o_stat_stalls != '1)) begin
                o_stat_stalls <= o_stat_stalls + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Vector-table bench for fifo_wr_arbiter (MAX_BURST=4 and =1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic           wr_full;

    logic [N-1:0]   ready0, grant0, ready1, grant1;
    logic           wr_en0, wr_en1, busy0, busy1;
    logic [W-1:0]   wr_data0, wr_data1;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [31:0]    stat_words0, stat_stalls0, stat_words1, stat_stalls1;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
        .o_req_ready(ready0), .o_grant(grant0), .o_wr_en(wr_en0),
        .o_wr_data(wr_data0), .i_wr_full(wr_full), .o_busy(busy0)
`ifdef FIFO_WR_ARB_STATS_EN
        , .o_stat_words(stat_words0), .o_stat_stalls(stat_stalls0)
`endif
    );

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(1)) u_dut_mb1 (
        .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
        .o_req_ready(ready1), .o_grant(grant1), .o_wr_en(wr_en1),
        .o_wr_data(wr_data1), .i_wr_full(wr_full), .o_busy(busy1)
`ifdef FIFO_WR_ARB_STATS_EN
        , .o_stat_words(stat_words1), .o_stat_stalls(stat_stalls1)
`endif
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        full;
        logic        we;
        logic [3:0]  grant;
        logic [7:0]  wdata;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_step = 0;

    task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d,
                       input logic f, input logic we, input logic [3:0] g,
                       input logic [7:0] wd);
        vec_t e;
        e.rst = r; e.valid = v; e.data = d; e.full = f;
        e.we = we; e.grant = g; e.wdata = wd;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, check combinational and state outputs 1ns later.
    task automatic apply_check(input vec_t e, input bit sel);
        logic [3:0] exp_ready;
        @(negedge clk);
        rst = e.rst; req_valid = e.valid; req_data = e.data; wr_full = e.full;
        #1;
        n_step++;
        exp_ready = e.we ? e.grant : 4'b0000;
        if (!sel) begin
            chk($sformatf("s%0d wr_en", n_step), 32'(wr_en0), 32'(e.we));
            chk($sformatf("s%0d grant", n_step), 32'(grant0), 32'(e.grant));
            chk($sformatf("s%0d ready", n_step), 32'(ready0), 32'(exp_ready));
            chk($sformatf("s%0d wr_data", n_step), 32'(wr_data0), 32'(e.wdata));
            chk($sformatf("s%0d busy", n_step), 32'(busy0), 32'(e.grant != 4'b0000));
        end else begin
            chk($sformatf("s%0d mb1 wr_en", n_step), 32'(wr_en1), 32'(e.we));
            chk($sformatf("s%0d mb1 grant", n_step), 32'(grant1), 32'(e.grant));
            chk($sformatf("s%0d mb1 ready", n_step), 32'(ready1), 32'(exp_ready));
            chk($sformatf("s%0d mb1 wr_data", n_step), 32'(wr_data1), 32'(e.wdata));
            chk($sformatf("s%0d mb1 busy", n_step), 32'(busy1), 32'(e.grant != 4'b0000));
        end
    endtask

    task automatic step(input bit sel, input logic r, input logic [3:0] v,
                        input logic [31:0] d, input logic f, input logic we,
                        input logic [3:0] g, input logic [7:0] wd);
        vec_t e;
        e.rst = r; e.valid = v; e.data = d; e.full = f;
        e.we = we; e.grant = g; e.wdata = wd;
        apply_check(e, sel);
    endtask

    initial begin
        // First reset cycle: outputs must already be gated even with valid high.
        rst = 1'b1; req_valid = 4'b1111; req_data = '0; wr_full = 1'b0;
        #1;
        chk("first_rst wr_en", 32'(wr_en0), 32'd0);
        chk("first_rst ready", 32'(ready0), 32'd0);
        @(negedge clk);
        req_valid = 4'b0000;

        // Single requester 1, incrementing data, two full bursts.
        add(1, 4'b0000, 32'h0, 0, 0, 4'b0000, 8'h00);
        add(0, 4'b0010, 32'h0000_1000, 0, 0, 4'b0000, 8'h00);
        for (int i = 0; i < 4; i++)
            add(0, 4'b0010, 32'h0000_1000 + 32'(i) * 32'h100, 0, 1, 4'b0010, 8'h10 + 8'(i));
        add(0, 4'b0010, 32'h0000_1400, 0, 0, 4'b0000, 8'h00);
        for (int i = 4; i < 8; i++)
            add(0, 4'b0010, 32'h0000_1000 + 32'(i) * 32'h100, 0, 1, 4'b0010, 8'h10 + 8'(i));
        add(0, 4'b0000, 32'h0, 0, 0, 4'b0000, 8'h00);

        // All four valid: grants 0,1,2,3,0 with one bubble between bursts.
        add(1, 4'b1111, 32'hA3A2_A1A0, 0, 0, 4'b0000, 8'h00);
        add(0, 4'b1111, 32'hA3A2_A1A0, 0, 0, 4'b0000, 8'h00);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++)
                add(0, 4'b1111, 32'hA3A2_A1A0, 0, 1, 4'(1 << k), 8'hA0 + 8'(k));
            add(0, 4'b1111, 32'hA3A2_A1A0, 0, 0, 4'b0000, 8'h00);
        end
        add(0, 4'b1111, 32'hA3A2_A1A0, 0, 1, 4'b0001, 8'hA0);
        add(0, 4'b0000, 32'hA3A2_A1A0, 0, 0, 4'b0001, 8'hA0);
        add(0, 4'b0000, 32'h0, 0, 0, 4'b0000, 8'h00);

        // Early drop by req0 after 2 words; req3 is next.
        add(1, 4'b0000, 32'h0, 0, 0, 4'b0000, 8'h00);
        add(0, 4'b1001, 32'h3000_0020, 0, 0, 4'b0000, 8'h00);
        add(0, 4'b1001, 32'h3000_0020, 0, 1, 4'b0001, 8'h20);
        add(0, 4'b1001, 32'h3000_0021, 0, 1, 4'b0001, 8'h21);
        add(0, 4'b1000, 32'h3000_0021, 0, 0, 4'b0001, 8'h21);
        add(0, 4'b1000, 32'h3000_0021, 0, 0, 4'b0000, 8'h00);
        add(0, 4'b1000, 32'h3000_0021, 0, 1, 4'b1000, 8'h30);
        add(0, 4'b0000, 32'h3000_0021, 0, 0, 4'b1000, 8'h30);

        // Reset during req3's second word; search restarts at index 0.
        add(0, 4'b1000, 32'h4000_0000, 0, 0, 4'b0000, 8'h00);
        add(0, 4'b1000, 32'h4000_0000, 0, 1, 4'b1000, 8'h40);
        add(1, 4'b1000, 32'h4100_0000, 0, 0, 4'b1000, 8'h41);
        add(0, 4'b1010, 32'h4100_5000, 0, 0, 4'b0000, 8'h00);
        add(0, 4'b1010, 32'h4100_5000, 0, 1, 4'b0010, 8'h50);
        add(0, 4'b0000, 32'h0, 0, 0, 4'b0010, 8'h00);
        add(0, 4'b0000, 32'h0, 0, 0, 4'b0000, 8'h00);

        for (int i = 0; i < tbl.size(); i++) apply_check(tbl[i], 1'b0);

        // Full stall for 5 cycles after req2's second word.
        step(0, 1, 4'b0000, 32'h0, 0, 0, 4'b0000, 8'h00);
        step(0, 0, 4'b0100, 32'h0060_0000, 0, 0, 4'b0000, 8'h00);
        step(0, 0, 4'b0100, 32'h0060_0000, 0, 1, 4'b0100, 8'h60);
        step(0, 0, 4'b0100, 32'h0061_0000, 0, 1, 4'b0100, 8'h61);
        for (int i = 0; i < 5; i++)
            step(0, 0, 4'b0100, 32'h0062_0000, 1, 0, 4'b0100, 8'h62);
        step(0, 0, 4'b0100, 32'h0062_0000, 0, 1, 4'b0100, 8'h62);
        step(0, 0, 4'b0100, 32'h0063_0000, 0, 1, 4'b0100, 8'h63);
        step(0, 0, 4'b0000, 32'h0, 0, 0, 4'b0000, 8'h00);
`ifdef FIFO_WR_ARB_STATS_EN
        chk("stat_words", stat_words0, 32'd4);
        chk("stat_stalls", stat_stalls0, 32'd5);
`endif

        // MAX_BURST=1 instance: alternating single-word grants.
        step(1, 1, 4'b0000, 32'h0, 0, 0, 4'b0000, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 4'b0011, 32'h0000_7170, 0, 0, 4'b0000, 8'h00);
            step(1, 0, 4'b0011, 32'h0000_7170, 0, 1, 4'(1 << (i % 2)), 8'h70 + 8'(i % 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
